switch_out_port_arbmux: RTL

Parametrised output port for the switch crossbar. It selects one of `N_IN` input flit streams, arbitrates round-robin between packet heads, and holds the winner until that packet's tail has passed (wormhole lock). The chosen flit goes through a single output register with valid/ready flow control. It replaces the fixed-width combinational output multiplexers in the generated switches and sits between the input buffers and the output link.

---
 rtl/noc_switch_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/switch_out_port_arbmux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/noc_switch_pkg.sv
// Shared types and helpers for the switch output-port datapath.
// rr_pick returns a one-hot round-robin winner among the first n request bits.
package noc_switch_pkg;

    localparam int MAX_N  = 16;
    localparam int MAX_PW = 4;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    // Search starts at ptr and wraps at n; ptr is always below n, so one subtraction suffices.
    function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0]  req,
                                                 input logic [MAX_PW-1:0] ptr,
                                                 input int                n);
        logic [MAX_N-1:0] gnt;
        logic             found;
        int               idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[MAX_PW-1:0]]) begin
                gnt[idx[MAX_PW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin arbiter: one-hot grant plus the winner index.
module rr_arbiter
    import noc_switch_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);

    logic [MAX_N-1:0]  req_pad;
    logic [MAX_N-1:0]  gnt_pad;
    logic [MAX_PW-1:0] ptr_pad;

    always_comb begin
        req_pad         = '0;
        req_pad[N-1:0]  = req_i;
        ptr_pad         = '0;
        ptr_pad[PW-1:0] = ptr_i;
        gnt_pad         = rr_pick(req_pad, ptr_pad, N);
        gnt_o           = gnt_pad[N-1:0];
        idx_o           = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (gnt_pad[i]) idx_o = PW'(i);
        end
    end

endmodule

// File: rtl/switch_out_port_arbmux.sv
// Switch output port: round-robin head arbitration, wormhole lock until tail,
// one registered output stage with valid/ready flow control.
module switch_out_port_arbmux
    import noc_switch_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int FLIT_W = 80
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN*FLIT_W-1:0]   in_flit,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0]          in_head,
    input  logic [N_IN-1:0]          in_tail,
    output logic [N_IN-1:0]          in_ready,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_head,
    output logic                     out_tail,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_IN-1:0]          grant
);

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

    state_e            state_q;
    logic [PW-1:0]     owner_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     rr_ptr_d;
    logic [N_IN-1:0]   grant_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic              out_head_q;
    logic              out_tail_q;
    logic              out_valid_q;

    logic              load_en;
    logic              accept;
    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   arb_gnt;
    logic [PW-1:0]     arb_idx;
    logic [N_IN-1:0]   sel;
    logic [FLIT_W-1:0] flit_mux;
    logic              head_mux;
    logic              tail_mux;

    assign load_en = !out_valid_q || out_ready;
    assign req     = in_valid & in_head;

    rr_arbiter #(.N(N_IN), .PW(PW)) u_arb (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // sel is the one-hot accepted input this cycle; it doubles as in_ready.
    always_comb begin
        sel = '0;
        if (!reset && load_en) begin
            if (state_q == ST_IDLE) sel = arb_gnt;
            else if (in_valid[owner_q]) sel[owner_q] = 1'b1;
        end
    end

    always_comb begin
        flit_mux = '0;
        head_mux = 1'b0;
        tail_mux = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            flit_mux = flit_mux | ({FLIT_W{sel[i]}} & in_flit[i*FLIT_W +: FLIT_W]);
            head_mux = head_mux | (sel[i] & in_head[i]);
            tail_mux = tail_mux | (sel[i] & in_tail[i]);
        end
    end

    assign accept   = |sel;
    assign rr_ptr_d = (arb_idx == PW'(N_IN - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_head_q  <= 1'b0;
            out_tail_q  <= 1'b0;
        end else begin
            if (load_en) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_flit_q <= flit_mux;
                    out_head_q <= head_mux;
                    out_tail_q <= tail_mux;
                end
            end
            // A stray head on the owner while locked is forwarded; only a tail releases the lock.
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (!tail_mux) begin
                            state_q <= ST_LOCKED;
                            owner_q <= arb_idx;
                            grant_q <= arb_gnt;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (accept && tail_mux) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = sel;
    assign out_flit  = out_flit_q;
    assign out_head  = out_head_q;
    assign out_tail  = out_tail_q;
    assign out_valid = out_valid_q;
    assign grant     = grant_q;

endmodule
